receptor_sonar_serial: RTL and testbench
========================================

// Module: receptor_sonar_serial
// PURPOSE
//  Receive end of the sonar serial link. Deserializes UART frames (7 data bits, even parity, 2 stop bits).
//  Parses the 8-character sonar message "AAA,DDD#" into BCD angle and distance registers.
//  Used in the monitoring board and in loopback benches against the sonar transmitter.
//  Emits a one-cycle pronto per valid message and a one-cycle erro per rejected character.
// PARAMETERS
//  CLKS_PER_BIT  434  clock cycles per bit (50 MHz / 115200 baud); must be >= 4
// PORTS
//  clock           in   1   system clock; sole clock domain
//  reset           in   1   synchronous, active-high reset
//  entrada_serial  in   1   serial line; idle high; asynchronous to clock
//  angulo          out  12  last valid angle, 3 BCD digits [11:8]=hundreds
//  distancia       out  12  last valid distance, 3 BCD digits [11:8]=hundreds
//  pronto          out  1   1-cycle pulse: angulo/distancia just updated
//  erro            out  1   1-cycle pulse: character rejected (parity/stop/format)
//  db_estado       out  4   bit-FSM state code, for hexa7seg debug display
// BEHAVIOUR
//  Reset (synchronous, any state)
//   - Outputs: angulo=0, distancia=0, pronto=0, erro=0, db_estado=0.
//   - Bit FSM -> OCIOSO; message position -> 0; sync flag set; synchronizer FFs loaded with 1.
//   - A frame in progress when reset asserts is discarded.
//  Input conditioning: entrada_serial passes a 2-FF synchronizer before any use.
//  Bit FSM (db_estado code):
//   - OCIOSO(0): wait for synchronized line = 0.
//   - INICIO(1): count CLKS_PER_BIT/2. Resample: 1 -> OCIOSO (glitch, no erro); 0 -> DADOS.
//   - DADOS(2): sample every CLKS_PER_BIT. 7 bits, LSB first, into shift register.
//   - PARIDADE(3): sample parity bit. Even parity over 7 data bits + parity bit.
//   - PARADA1(4): sample; must be 1.
//   - PARADA2(5): sample; must be 1.
//   - AVALIA(6): one cycle; evaluate the character; -> OCIOSO.
//  Character check in AVALIA, by position p (0..7):
//   - p=0..2 and p=4..6: ASCII digit 0x30..0x39.
//   - p=3: ','=0x2C.
//   - p=7: '#'=0x23.
//   - Digit low nibble goes to a shadow register: p0..2 -> angle [11:8],[7:4],[3:0]; p4..6 -> distance, same order.
//  Valid '#' at p=7:
//   - Copy shadow registers to angulo/distancia and pulse pronto on the cycle after AVALIA.
//   - p -> 0.
//   - Latency: pronto rises 2 clocks after the PARADA2 sample point.
//  Error handling (parity fail, stop bit = 0, or wrong character for p):
//   - Pulse erro one cycle after AVALIA. Shadow registers discarded; outputs keep their old values.
//   - If the bad character was nonetheless a correctly framed '#': p -> 0 (resynchronized).
//   - Otherwise set sync flag.
//  Sync flag:
//   - While set, all characters are ignored (no erro) until a correctly framed '#'.
//   - That '#' clears the flag and sets p -> 0.
//   - The flag is set at reset, so the first message after reset is accepted only after one '#'.
//  Outputs and timing:
//   - angulo/distancia change only on pronto and hold indefinitely between messages.
//   - pronto and erro are never asserted in the same cycle.
//   - A start bit arriving right after PARADA2 is detected normally; AVALIA overlaps OCIOSO edge detection with no loss.
//   - The line is not checked during idle gaps; any gap length between characters is accepted.
// TESTING (bench uses CLKS_PER_BIT=8)
//  1) reset, send "#" then "090,123#" -> one pronto; angulo=12'h090, distancia=12'h123; erro never high.
//  2) Send "045,007#" then "180,999#" back-to-back with no idle gap -> two pronto pulses; final angulo=12'h180, distancia=12'h999.
//  3) Corrupt the parity of the 5th char of "120,050#" -> one erro pulse, no pronto, outputs hold prior values.
//     Then a valid "030,020#" -> pronto; angulo=12'h030.
//  4) Send "12X,456#" -> erro at 'X', remaining chars ignored, no pronto.
//     The trailing '#' resyncs; next "150,300#" -> pronto with those values.
//  5) 3-cycle low glitch on idle line -> bit FSM returns to OCIOSO; no erro, no pronto.
//  6) Assert reset mid-DADOS of 4th char -> all outputs 0 next cycle.
//     Then "#"+"060,010#" -> pronto; angulo=12'h060, distancia=12'h010.

Source files
------------

// File: rtl/receptor_sonar_serial.sv
// Receive end of the sonar serial link.
// Deserializes 7E2 UART characters and parses the 8-character message "AAA,DDD#"
// into BCD angle and distance registers. pronto marks an accepted message and
// erro marks a rejected character; the two never fire in the same cycle.
module receptor_sonar_serial #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        entrada_serial,
    output logic [11:0] angulo,
    output logic [11:0] distancia,
    output logic        pronto,
    output logic        erro,
    output logic [3:0]  db_estado
);

    typedef enum logic [3:0] {
        OCIOSO   = 4'd0,
        INICIO   = 4'd1,
        DADOS    = 4'd2,
        PARIDADE = 4'd3,
        PARADA1  = 4'd4,
        PARADA2  = 4'd5,
        AVALIA   = 4'd6
    } estado_t;

    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

    estado_t       estado, prox_estado;
    logic          sync_meta, rx;
    logic [CW-1:0] cnt;
    logic          tick;
    logic [2:0]    bit_idx;
    logic [6:0]    shift;
    logic          par_ok, stop_ok;
    logic [2:0]    pos;
    logic          sync_flag;
    logic [11:0]   sh_ang, sh_dist;
    logic          framed, is_digit, is_comma, is_hash, char_ok;

    // Two-flop synchronizer; loads idle level on reset so no false start is seen.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_meta <= 1'b1;
            rx        <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make both flops sample the old values,
            // giving a real two-stage chain rather than a single wire.
            sync_meta <= entrada_serial;
            rx        <= sync_meta;
        end
    end

    // Bit FSM state register.
    always_ff @(posedge clock) begin
        if (reset) estado <= OCIOSO;
        else       estado <= prox_estado;
    end

    // Bit FSM next-state: start bit is resampled at half a bit, the rest at full bit periods.
    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        prox_estado = estado;
        tick        = (estado == INICIO) ? (cnt == HALF_M1) : (cnt == FULL_M1);
        case (estado)
            OCIOSO:   if (!rx) prox_estado = INICIO;
            INICIO:   if (tick) prox_estado = rx ? OCIOSO : DADOS;
            DADOS:    if (tick && bit_idx == 3'd6) prox_estado = PARIDADE;
            PARIDADE: if (tick) prox_estado = PARADA1;
            PARADA1:  if (tick) prox_estado = PARADA2;
            PARADA2:  if (tick) prox_estado = AVALIA;
            // A start bit already visible here is taken without passing through OCIOSO.
            AVALIA:   prox_estado = rx ? OCIOSO : INICIO;
            default:  prox_estado = OCIOSO;
        endcase
    end

    // Character classification, used only while in AVALIA.
    always_comb begin
        framed   = par_ok && stop_ok;
        is_digit = (shift[6:4] == 3'b011) && (shift[3:0] <= 4'd9);
        is_comma = (shift == 7'h2C);
        is_hash  = (shift == 7'h23);
        case (pos)
            3'd3:    char_ok = is_comma;
            3'd7:    char_ok = is_hash;
            default: char_ok = is_digit;
        endcase
    end

    // Bit timing, shift register and frame checks.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt     <= '0;
            bit_idx <= '0;
            par_ok  <= 1'b0;
            stop_ok <= 1'b0;
        end else begin
            if (estado == OCIOSO || prox_estado != estado || tick) cnt <= '0;
            else                                                  cnt <= cnt + 1'b1;

            if (estado != DADOS) bit_idx <= '0;
            else if (tick)       bit_idx <= bit_idx + 3'd1;

            if (tick) begin
                case (estado)
                    DADOS:    shift   <= {rx, shift[6:1]};
                    PARIDADE: par_ok  <= ~(^{shift, rx});
                    PARADA1:  stop_ok <= rx;
                    PARADA2:  stop_ok <= stop_ok & rx;
                    default:  ;
                endcase
            end
        end
    end

    // Message parser: shadow digits, commit on '#', error and resync handling.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: shadow and shift registers are not reset; they are always
            // rewritten before being read, so only control state needs clearing.
            angulo    <= '0;
            distancia <= '0;
            pronto    <= 1'b0;
            erro      <= 1'b0;
            pos       <= '0;
            sync_flag <= 1'b1;
        end else begin
            pronto <= 1'b0;
            erro   <= 1'b0;
            if (estado == AVALIA) begin
                if (sync_flag) begin
                    if (framed && is_hash) begin
                        sync_flag <= 1'b0;
                        pos       <= '0;
                    end
                end else if (framed && char_ok) begin
                    case (pos)
                        3'd0: sh_ang[11:8]  <= shift[3:0];
                        3'd1: sh_ang[7:4]   <= shift[3:0];
                        3'd2: sh_ang[3:0]   <= shift[3:0];
                        3'd4: sh_dist[11:8] <= shift[3:0];
                        3'd5: sh_dist[7:4]  <= shift[3:0];
                        3'd6: sh_dist[3:0]  <= shift[3:0];
                        3'd7: begin
                            angulo    <= sh_ang;
                            distancia <= sh_dist;
                            pronto    <= 1'b1;
                        end
                        default: ;
                    endcase
                    pos <= pos + 3'd1;  // wraps 7 -> 0 after the '#'
                end else begin
                    erro <= 1'b1;
                    if (framed && is_hash) pos <= '0;
                    else                   sync_flag <= 1'b1;
                end
            end
        end
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_receptor_sonar_serial.sv
// Directed bench for receptor_sonar_serial with CLKS_PER_BIT = 8.
module tb_receptor_sonar_serial;

    localparam int CPB = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        entrada_serial = 1'b1;
    logic [11:0] angulo, distancia;
    logic        pronto, erro;
    logic [3:0]  db_estado;

    int checks = 0;
    int failures = 0;
    int pronto_total = 0;
    int erro_total = 0;
    int viol = 0;
    logic [11:0] prev_ang = '0, prev_dist = '0;

    receptor_sonar_serial #(.CLKS_PER_BIT(CPB)) dut (
        .clock          (clock),
        .reset          (reset),
        .entrada_serial (entrada_serial),
        .angulo         (angulo),
        .distancia      (distancia),
        .pronto         (pronto),
        .erro           (erro),
        .db_estado      (db_estado)
    );

    always #5 clock = ~clock;

    // Pulse counters and output-stability monitor.
    always @(negedge clock) begin
        if (!reset) begin
            if (pronto) pronto_total++;
            if (erro) erro_total++;
            if (pronto && erro) viol++;
            if (!pronto && (angulo !== prev_ang || distancia !== prev_dist)) viol++;
        end
        prev_ang  = angulo;
        prev_dist = distancia;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sends the first n_bits of a 7E2 frame; called and returns on a falling edge.
    task automatic send_char(input byte c, input bit bad_par, input int n_bits);
        logic [10:0] fr;
        logic        p;
        p  = (^c[6:0]) ^ bad_par;
        fr = {2'b11, p, c[6:0], 1'b0};
        for (int i = 0; i < n_bits; i++) begin
            entrada_serial = fr[i];
            repeat (CPB) @(negedge clock);
        end
        entrada_serial = 1'b1;
    endtask

    typedef struct {
        string       name;
        string       text;
        int          bad_idx;
        int          exp_pronto;
        int          exp_erro;
        logic [11:0] exp_ang;
        logic [11:0] exp_dist;
    } vec_t;

    task automatic apply_vec(input vec_t v);
        int p0, e0;
        p0 = pronto_total;
        e0 = erro_total;
        for (int i = 0; i < v.text.len(); i++)
            send_char(v.text[i], (i == v.bad_idx), 11);
        repeat (20) @(negedge clock);
        check({v.name, "_pronto"}, pronto_total - p0, v.exp_pronto);
        check({v.name, "_erro"}, erro_total - e0, v.exp_erro);
        check({v.name, "_angulo"}, angulo, v.exp_ang);
        check({v.name, "_distancia"}, distancia, v.exp_dist);
    endtask

    vec_t vecs [6];
    vec_t vec_post;
    int   p_before, e_before;
    bit   saw_inicio;

    initial begin
        vecs[0] = '{"first_msg",   "#090,123#",         -1, 1, 0, 12'h090, 12'h123};
        vecs[1] = '{"back2back",   "045,007#180,999#",  -1, 2, 0, 12'h180, 12'h999};
        vecs[2] = '{"bad_parity",  "120,050#",           4, 0, 1, 12'h180, 12'h999};
        vecs[3] = '{"after_par",   "030,020#",          -1, 1, 0, 12'h030, 12'h020};
        vecs[4] = '{"bad_char",    "12X,456#",          -1, 0, 1, 12'h030, 12'h020};
        vecs[5] = '{"resynced",    "150,300#",          -1, 1, 0, 12'h150, 12'h300};
        vec_post = '{"post_reset", "#060,010#",         -1, 1, 0, 12'h060, 12'h010};

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_angulo", angulo, 12'h000);
        check("rst_distancia", distancia, 12'h000);
        check("rst_pronto", pronto, 1'b0);
        check("rst_erro", erro, 1'b0);
        check("rst_estado", db_estado, 4'd0);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        for (int i = 0; i < 6; i++) apply_vec(vecs[i]);

        // Short low glitch on idle line
        p_before = pronto_total;
        e_before = erro_total;
        saw_inicio = 1'b0;
        entrada_serial = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (k == 2) entrada_serial = 1'b1;
            if (db_estado == 4'd1) saw_inicio = 1'b1;
        end
        check("glitch_saw_inicio", saw_inicio, 1'b1);
        check("glitch_back_idle", db_estado, 4'd0);
        check("glitch_no_pulses", (pronto_total - p_before) + (erro_total - e_before), 0);

        // Reset in the middle of the data bits of the 4th character
        send_char("1", 1'b0, 11);
        send_char("5", 1'b0, 11);
        send_char("0", 1'b0, 11);
        send_char(",", 1'b0, 4);
        check("mid_dados_estado", db_estado, 4'd2);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_angulo", angulo, 12'h000);
        check("mid_rst_distancia", distancia, 12'h000);
        check("mid_rst_pronto", pronto, 1'b0);
        check("mid_rst_erro", erro, 1'b0);
        check("mid_rst_estado", db_estado, 4'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        apply_vec(vec_post);

        check("protocol_violations", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
